adc_ltc2308_emu: RTL and testbench

Synthesizable responder that emulates the LTC2308 serial interface, the device end of the ADC SPI link. It lets the ADC master be exercised in hardware loopback or simulation without the physical IC. It decodes CONVST/SCK/SDI, applies the pipelined 6-bit configuration, converts user-supplied 8-channel 12-bit values into output codes, and shifts them out on SDO. All pins are oversampled on one fast system clock.

---
 rtl/adc_ltc2308_emu_pkg.sv | 44 ++++
 rtl/adc_ltc2308_emu_if.sv | 30 +++
 rtl/adc_ltc2308_emu_sync.sv | 32 +++
 rtl/adc_ltc2308_emu.sv | 218 +++++++++++++++++++++
 tb/tb_adc_ltc2308_emu.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/adc_ltc2308_emu_pkg.sv
// Shared constants, state encoding and channel-select decode for the LTC2308 emulator.
// Configuration word layout is {S/D, O/S, S1, S0, UNI, SLP}, MSB first on SDI.
package adc_ltc2308_pkg;

  localparam int CFG_W  = 6;
  localparam int CODE_W = 12;
  localparam int NUM_CH = 8;

  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  localparam logic [CFG_W-1:0] CFG_RESET_VAL = 6'b100010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_READ = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] p_idx;
    logic [2:0] n_idx;
    logic       is_single;
  } chsel_t;

  // Single-ended: channel {S1,S0,O/S}. Differential pair k={S1,S0}: O/S picks
  // which member of the pair is the positive input.
  function automatic chsel_t cfg_to_chsel(input logic [CFG_W-1:0] cfg);
    chsel_t s;
    s.is_single = cfg[CFG_SD];
    s.p_idx     = {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
    if (cfg[CFG_SD]) begin
      s.n_idx = 3'd0;
    end else begin
      s.n_idx = {cfg[CFG_S1], cfg[CFG_S0], ~cfg[CFG_OS]};
    end
    return s;
  endfunction

endpackage

// File: rtl/adc_ltc2308_emu_if.sv
// Pin and status bundle between an LTC2308 master and the emulator.
// Signal prefixes are from the emulator's point of view.
interface adc_ltc2308_emu_if;
  import adc_ltc2308_pkg::*;

  logic                       i_convst;
  logic                       i_sck;
  logic                       i_sdi;
  logic [NUM_CH*CODE_W-1:0]   i_ch_data;
  logic                       o_sdo;
  logic                       o_busy;
  logic [CFG_W-1:0]           o_cfg_active;
  logic                       o_cfg_load;
  logic                       o_conv_done;
  logic [CODE_W-1:0]          o_sample_code;
  logic                       o_protocol_err;

  modport master (
    output i_convst, i_sck, i_sdi, i_ch_data,
    input  o_sdo, o_busy, o_cfg_active, o_cfg_load, o_conv_done,
           o_sample_code, o_protocol_err
  );

  modport slave (
    input  i_convst, i_sck, i_sdi, i_ch_data,
    output o_sdo, o_busy, o_cfg_active, o_cfg_load, o_conv_done,
           o_sample_code, o_protocol_err
  );

endinterface

// File: rtl/adc_ltc2308_emu_sync.sv
// Two-flop synchronizer for one asynchronous pin plus rise/fall detection.
// Edge strobes are valid two clocks after the pin changes.
module adc_ltc2308_emu_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/adc_ltc2308_emu.sv
// Device-side LTC2308 responder: decodes CONVST/SCK/SDI, converts ch_data to a code
// with the pipelined 6-bit configuration and shifts it out on SDO after each SCK rise.
module adc_ltc2308_emu
  import adc_ltc2308_pkg::*;
#(
  parameter int               TCONV_CLKS = 256,
  parameter logic [CFG_W-1:0] CFG_RESET  = CFG_RESET_VAL
) (
  input  logic              i_clock,
  input  logic              i_reset,
  adc_ltc2308_emu_if.slave  bus
);

  localparam int CNT_W = (TCONV_CLKS > 1) ? $clog2(TCONV_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TCONV_CLKS - 1);
  localparam logic signed [CODE_W:0] D_MAX = 13'sd2047;
  localparam logic signed [CODE_W:0] D_MIN = -13'sd2048;

  logic w_convst_rise, w_convst_fall, w_convst_lvl;
  logic w_sck_rise, w_sck_fall, w_sck_lvl;
  logic w_sdi, w_sdi_rise, w_sdi_fall;
  logic w_unused;

  adc_ltc2308_emu_sync u_sync_convst (
    .i_clk   (i_clock),
    .i_rst   (i_reset),
    .i_pin   (bus.i_convst),
    .o_level (w_convst_lvl),
    .o_rise  (w_convst_rise),
    .o_fall  (w_convst_fall)
  );

  adc_ltc2308_emu_sync u_sync_sck (
    .i_clk   (i_clock),
    .i_rst   (i_reset),
    .i_pin   (bus.i_sck),
    .o_level (w_sck_lvl),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  adc_ltc2308_emu_sync u_sync_sdi (
    .i_clk   (i_clock),
    .i_rst   (i_reset),
    .i_pin   (bus.i_sdi),
    .o_level (w_sdi),
    .o_rise  (w_sdi_rise),
    .o_fall  (w_sdi_fall)
  );

  assign w_unused = ^{w_convst_lvl, w_convst_fall, w_sck_lvl, w_sck_fall,
                      w_sdi_rise, w_sdi_fall};

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CODE_W-1:0]    r_code_calc;
  logic [CODE_W-1:0]    r_shift;
  logic [CODE_W-1:0]    r_sample_code;
  logic [3:0]           r_edge_cnt;
  logic [CFG_W-1:0]     r_cap;
  logic [CFG_W-1:0]     r_cfg_active;
  logic                 r_sdo;
  logic                 r_busy;
  logic                 r_cfg_load;
  logic                 r_conv_done;
  logic                 r_protocol_err;

  logic                 w_start;
  logic                 w_conv_end;
  logic                 w_err;
  logic                 w_read_edge;

  // Code computation against the configuration currently in force
  chsel_t               w_sel;
  logic [CODE_W-1:0]    w_ch [NUM_CH];
  logic [CODE_W-1:0]    w_p;
  logic [CODE_W-1:0]    w_n;
  logic signed [CODE_W:0] w_diff;
  logic [CODE_W-1:0]    w_code;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_ch[i] = bus.i_ch_data[CODE_W*i +: CODE_W];
    end
  end

  assign w_sel  = cfg_to_chsel(r_cfg_active);
  assign w_p    = w_ch[w_sel.p_idx];
  assign w_n    = w_sel.is_single ? '0 : w_ch[w_sel.n_idx];
  assign w_diff = $signed({1'b0, w_p}) - $signed({1'b0, w_n});

  always_comb begin
    w_code = w_p;
    if (r_cfg_active[CFG_UNI]) begin
      if (!w_sel.is_single) begin
        w_code = w_diff[CODE_W] ? '0 : w_diff[CODE_W-1:0];
      end
    end else begin
      if (w_diff > D_MAX) begin
        w_code = 12'h7FF;
      end else if (w_diff < D_MIN) begin
        w_code = 12'h800;
      end else begin
        w_code = w_diff[CODE_W-1:0];
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_conv_end  = 1'b0;
    w_err       = 1'b0;
    w_read_edge = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_convst_rise) begin
          w_start     = 1'b1;
          w_state_nxt = ST_CONV;
        end
      end
      ST_CONV: begin
        // Master activity during conversion is flagged but never disturbs timing
        w_err = w_convst_rise | w_sck_rise;
        if (r_cnt == '0) begin
          w_conv_end  = 1'b1;
          w_state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        if (w_convst_rise) begin
          w_start     = 1'b1;
          w_state_nxt = ST_CONV;
        end else if (w_sck_rise) begin
          w_read_edge = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt          <= '0;
      r_code_calc    <= '0;
      r_shift        <= '0;
      r_sample_code  <= '0;
      r_edge_cnt     <= '0;
      r_cap          <= '0;
      r_cfg_active   <= CFG_RESET;
      r_sdo          <= 1'b0;
      r_busy         <= 1'b0;
      r_cfg_load     <= 1'b0;
      r_conv_done    <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      r_cfg_load     <= 1'b0;
      r_conv_done    <= 1'b0;
      r_protocol_err <= w_err;

      if (w_start) begin
        r_code_calc <= w_code;
        r_cnt       <= CNT_LOAD;
        r_busy      <= 1'b1;
        r_edge_cnt  <= '0;
        r_cap       <= '0;
        r_sdo       <= 1'b0;
      end else if (r_state == ST_CONV) begin
        if (w_conv_end) begin
          r_busy        <= 1'b0;
          r_conv_done   <= 1'b1;
          r_sample_code <= r_code_calc;
          r_shift       <= r_code_calc;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end

      // r_edge_cnt holds the number of SCK rises already seen in this readout
      if (w_read_edge) begin
        if (r_edge_cnt != 4'd15) begin
          r_edge_cnt <= r_edge_cnt + 1'b1;
        end
        if (r_edge_cnt < 4'd12) begin
          r_sdo   <= r_shift[CODE_W-1];
          r_shift <= {r_shift[CODE_W-2:0], 1'b0};
        end else begin
          r_sdo <= 1'b0;
        end
        if (r_edge_cnt < 4'd6) begin
          r_cap <= {r_cap[CFG_W-2:0], w_sdi};
        end
        if (r_edge_cnt == 4'd5) begin
          r_cfg_active <= {r_cap[CFG_W-2:0], w_sdi};
          r_cfg_load   <= 1'b1;
        end
      end
    end
  end

  assign bus.o_sdo          = r_sdo;
  assign bus.o_busy         = r_busy;
  assign bus.o_cfg_active   = r_cfg_active;
  assign bus.o_cfg_load     = r_cfg_load;
  assign bus.o_conv_done    = r_conv_done;
  assign bus.o_sample_code  = r_sample_code;
  assign bus.o_protocol_err = r_protocol_err;

endmodule

// File: tb/tb_adc_ltc2308_emu.sv
// Bench for adc_ltc2308_emu: table of conversions with hand-derived codes, plus
// sequences for protocol errors, partial configuration words and mid-readout reset.
`timescale 1ns/1ps
module tb_adc_ltc2308_emu;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  adc_ltc2308_emu_if u_if ();

  adc_ltc2308_emu #(
    .TCONV_CLKS (256),
    .CFG_RESET  (6'b100010)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (u_if)
  );

  typedef struct {
    logic [5:0]  send;
    logic [11:0] ch0;
    logic [11:0] ch1;
    logic [11:0] ch7;
    logic [11:0] exp_code;
  } vec_t;

  vec_t        tbl [8];
  logic [11:0] exp_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  int busy_cycles = 0;
  int done_cnt    = 0;
  int load_cnt    = 0;
  int err_cnt     = 0;

  always @(negedge clk) begin
    busy_cycles <= busy_cycles + int'(u_if.o_busy);
    done_cnt    <= done_cnt + int'(u_if.o_conv_done);
    load_cnt    <= load_cnt + int'(u_if.o_cfg_load);
    err_cnt     <= err_cnt + int'(u_if.o_protocol_err);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [95:0] make_ch(input logic [11:0] c0, input logic [11:0] c1,
                                          input logic [11:0] c7);
    logic [95:0] v;
    for (int i = 0; i < 8; i++) v[12*i +: 12] = 12'h3A0 + 12'(i);
    v[11:0]  = c0;
    v[23:12] = c1;
    v[95:84] = c7;
    return v;
  endfunction

  task automatic pulse_convst();
    u_if.i_convst = 1'b1;
    wait_clks(4);
    u_if.i_convst = 1'b0;
  endtask

  task automatic wait_conv(input int d0);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 1000) begin
      wait_clks(1);
      t++;
    end
    check("conv_done_seen", 32'(done_cnt != d0), 32'd1);
    wait_clks(2);
  endtask

  // Master side of a readout: SDI set while SCK low, SDO sampled just before each fall
  task automatic readout(input int nedges, input logic [5:0] word, output logic [11:0] code);
    int l0;
    l0   = load_cnt;
    code = '0;
    for (int e = 1; e <= nedges; e++) begin
      u_if.i_sdi = (e <= 6) ? word[6-e] : 1'b0;
      wait_clks(2);
      u_if.i_sck = 1'b1;
      wait_clks(8);
      if (e <= 12) code = {code[10:0], u_if.o_sdo};
      else check("sdo_after_12", 32'(u_if.o_sdo), 32'd0);
      if (e == 5) check("cfg_load_before_6", 32'(load_cnt - l0), 32'd0);
      if (e == 6) check("cfg_load_at_6", 32'(load_cnt - l0), 32'd1);
      u_if.i_sck = 1'b0;
      wait_clks(6);
    end
    u_if.i_sdi = 1'b0;
  endtask

  initial begin
    int          b0, d0, e0;
    logic [11:0] code;
    logic [11:0] exp;

    tbl[0] = '{6'b110010, 12'hABC, 12'h123, 12'h000, 12'hABC};
    tbl[1] = '{6'b000010, 12'hABC, 12'h123, 12'h000, 12'h123};
    tbl[2] = '{6'b010010, 12'h100, 12'h180, 12'h000, 12'h000};
    tbl[3] = '{6'b100000, 12'h100, 12'h180, 12'h000, 12'h080};
    tbl[4] = '{6'b000000, 12'hFFF, 12'h000, 12'h000, 12'h7FF};
    tbl[5] = '{6'b111110, 12'h000, 12'hFFF, 12'h000, 12'h800};
    tbl[6] = '{6'b100010, 12'h111, 12'h222, 12'hDEF, 12'hDEF};
    tbl[7] = '{6'b100010, 12'h7E1, 12'h222, 12'hDEF, 12'h7E1};

    rst            = 1'b1;
    u_if.i_convst  = 1'b0;
    u_if.i_sck     = 1'b0;
    u_if.i_sdi     = 1'b0;
    u_if.i_ch_data = '0;
    wait_clks(5);
    check("rst_sdo", 32'(u_if.o_sdo), 32'd0);
    check("rst_busy", 32'(u_if.o_busy), 32'd0);
    check("rst_cfg_active", 32'(u_if.o_cfg_active), 32'h22);
    check("rst_sample_code", 32'(u_if.o_sample_code), 32'd0);
    check("rst_pulses", 32'({u_if.o_cfg_load, u_if.o_conv_done, u_if.o_protocol_err}), 32'd0);
    rst = 1'b0;
    wait_clks(5);

    for (int i = 0; i < 8; i++) begin
      b0 = busy_cycles; d0 = done_cnt; e0 = err_cnt;
      u_if.i_ch_data = make_ch(tbl[i].ch0, tbl[i].ch1, tbl[i].ch7);
      exp_q.push_back(tbl[i].exp_code);
      pulse_convst();
      wait_conv(d0);
      check($sformatf("v%0d_busy_len", i), 32'(busy_cycles - b0), 32'd256);
      check($sformatf("v%0d_done_cnt", i), 32'(done_cnt - d0), 32'd1);
      check($sformatf("v%0d_sample_code", i), 32'(u_if.o_sample_code), 32'(tbl[i].exp_code));
      readout(13, tbl[i].send, code);
      exp = exp_q.pop_front();
      check($sformatf("v%0d_sdo_code", i), 32'(code), 32'(exp));
      check($sformatf("v%0d_cfg_active", i), 32'(u_if.o_cfg_active), 32'(tbl[i].send));
      check($sformatf("v%0d_no_err", i), 32'(err_cnt - e0), 32'd0);
      wait_clks(10);
    end

    // Extra CONVST and an SCK rise during conversion: flagged, conversion untouched
    b0 = busy_cycles; d0 = done_cnt; e0 = err_cnt;
    u_if.i_ch_data = make_ch(12'h321, 12'h222, 12'h333);
    exp_q.push_back(12'h321);
    pulse_convst();
    wait_clks(124);
    u_if.i_ch_data = make_ch(12'h999, 12'h222, 12'h333);
    pulse_convst();
    wait_clks(60);
    u_if.i_sck = 1'b1;
    wait_clks(8);
    u_if.i_sck = 1'b0;
    wait_conv(d0);
    check("perr_count", 32'(err_cnt - e0), 32'd2);
    check("perr_busy_len", 32'(busy_cycles - b0), 32'd256);
    check("perr_done_cnt", 32'(done_cnt - d0), 32'd1);
    readout(12, 6'b111110, code);
    exp = exp_q.pop_front();
    check("perr_sdo_code", 32'(code), 32'(exp));
    wait_clks(10);

    // Partial configuration word is dropped at the next CONVST
    d0 = done_cnt;
    u_if.i_ch_data = make_ch(12'h010, 12'h020, 12'h456);
    exp_q.push_back(12'h456);
    pulse_convst();
    wait_conv(d0);
    readout(4, 6'b000000, code);
    exp = exp_q.pop_front();
    check("partial_msbs", 32'(code[3:0]), 32'(exp[11:8]));
    d0 = done_cnt;
    u_if.i_ch_data = make_ch(12'h010, 12'h020, 12'h789);
    exp_q.push_back(12'h789);
    pulse_convst();
    wait_clks(8);
    check("partial_cfg_kept", 32'(u_if.o_cfg_active), 32'h3E);
    wait_conv(d0);
    readout(12, 6'b111110, code);
    exp = exp_q.pop_front();
    check("partial_sdo_code", 32'(code), 32'(exp));
    wait_clks(10);

    // Reset in the middle of a readout
    d0 = done_cnt;
    u_if.i_ch_data = make_ch(12'h5A5, 12'h020, 12'hAAA);
    exp_q.push_back(12'hAAA);
    pulse_convst();
    wait_conv(d0);
    readout(3, 6'b000000, code);
    exp = exp_q.pop_front();
    check("mid_read_msbs", 32'(code[2:0]), 32'(exp[11:9]));
    check("mid_read_sdo_hi", 32'(u_if.o_sdo), 32'd1);
    rst = 1'b1;
    wait_clks(1);
    check("mid_rst_sdo", 32'(u_if.o_sdo), 32'd0);
    check("mid_rst_cfg", 32'(u_if.o_cfg_active), 32'h22);
    check("mid_rst_busy", 32'(u_if.o_busy), 32'd0);
    check("mid_rst_sample", 32'(u_if.o_sample_code), 32'd0);
    exp_q.delete();
    wait_clks(3);
    rst = 1'b0;
    wait_clks(5);
    d0 = done_cnt;
    exp_q.push_back(12'h5A5);
    pulse_convst();
    wait_conv(d0);
    readout(12, 6'b100010, code);
    exp = exp_q.pop_front();
    check("post_rst_code", 32'(code), 32'(exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
